// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the KGP-RISC fetch sequencer: FSM state
// encoding, next-PC select codes and the PC increment / alignment constants.
package pc_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_SEQ    = 2'd1,
    SEL_TARGET = 2'd2
  } pc_sel_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hFFFF_FFFC;
  localparam logic [1:0]  ALIGN_MASK       = 2'b00;
  localparam int unsigned TIMER_W          = 16;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: hold, sequential (+4, wrapping modulo 2^32) or redirect
// target, plus a misalignment flag for the redirect target.
module pc_next_mux
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc_next,
  output logic        o_misaligned
);

  always_comb begin
    o_pc_next = i_pc;
    case (pc_sel_e'(i_sel))
      SEL_SEQ:    o_pc_next = i_pc + PC_INC;
      SEL_TARGET: o_pc_next = i_target;
      default:    o_pc_next = i_pc;
    endcase
  end

  assign o_misaligned = !is_aligned(i_target);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter and instruction-fetch sequencer: one imem request at a time,
// each fetched word handed to the datapath over a valid/ready handshake.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);

  state_e               r_state;
  state_e               w_state_next;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc_next;
  pc_sel_e              w_pc_sel;
  logic                 w_misaligned;
  logic [TIMER_W-1:0]   r_cnt;
  logic [TIMER_W-1:0]   w_cnt_next;
  logic                 w_capture;
  logic [31:0]          r_instr;
  logic [31:0]          r_instr_pc;
  logic                 r_imem_req;
  logic                 r_instr_valid;
  logic                 r_halted;
  logic                 r_fault;

  pc_next_mux u_pc_next_mux (
    .i_pc         (r_pc),
    .i_sel        (w_pc_sel),
    .i_target     (redirect_target),
    .o_pc_next    (w_pc_next),
    .o_misaligned (w_misaligned)
  );

  // NOTE: every signal is given a default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_sel     = SEL_HOLD;
    w_cnt_next   = '0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_pc_sel     = SEL_SEQ;
          w_state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_capture    = 1'b1;
          w_state_next = ST_ISSUE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_next = ST_FAULT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_ISSUE: begin
        // Control inputs only matter on the cycle the datapath accepts.
        if (instr_ready) begin
          if (halt_req) begin
            w_state_next = ST_HALTED;
          end else if (redirect_valid && w_misaligned) begin
            w_state_next = ST_FAULT;
          end else if (redirect_valid) begin
            w_pc_sel     = SEL_TARGET;
            w_state_next = ST_FETCH;
          end else begin
            w_pc_sel     = SEL_SEQ;
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        if (start) begin
          w_pc_sel     = SEL_SEQ;
          w_state_next = ST_FETCH;
        end
      end
      ST_FAULT: w_state_next = ST_FAULT;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_cnt         <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_cnt         <= w_cnt_next;
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      // Status outputs are registered from the next state so they never glitch.
      r_imem_req    <= (w_state_next == ST_FETCH);
      r_instr_valid <= (w_state_next == ST_ISSUE);
      r_halted      <= (w_state_next == ST_HALTED);
      r_fault       <= (w_state_next == ST_FAULT);
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sequences program-counter update and instruction fetch for the KGP-RISC core.
- Owns the architectural PC register and issues one request at a time to instruction memory over a req/ack handshake.
- Presents each fetched instruction to the datapath over a valid/ready handshake.
- Applies sequential (+4), branch/jump redirect, halt and fault control at instruction boundaries.

Parameters:
- RESET_PC, 32'hFFFF_FFFC, PC value after reset; the first +4 yields address 0.
- TIMEOUT, 16, maximum FETCH cycles without imem_ack before entering FAULT (range 2..65535).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse: leave IDLE or HALTED and fetch at pc+4
- imem_req  output  1  instruction memory request
- imem_addr  output  32  fetch address, equal to pc
- imem_ack  input  1  memory completed the request; imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction word
- instr_valid  output  1  instr/instr_pc valid for the datapath
- instr  output  32  registered instruction word
- instr_pc  output  32  address of instr
- instr_ready  input  1  datapath accepts instr (low = stall)
- redirect_valid  input  1  accepted instruction is a taken branch/jump
- redirect_target  input  32  target address for a redirect
- halt_req  input  1  accepted instruction is a halt
- pc  output  32  current PC register
- halted  output  1  high in HALTED
- fault  output  1  high in FAULT (sticky until rst)

Behaviour:
- States: IDLE, FETCH, ISSUE, HALTED, FAULT.
- Reset values (asynchronous, immediate): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fault=0, timeout counter=0.
- IDLE: imem_req=0. start -> pc<=pc+4 and go to FETCH.
- FETCH: imem_req=1. imem_addr=pc, held stable until ack.
  - Counter increments each FETCH cycle without ack.
  - imem_ack -> instr<=imem_rdata, instr_pc<=pc, counter cleared, go to ISSUE.
  - Counter reaching TIMEOUT-1 without ack -> FAULT.
  - Ack in the same cycle as req is legal (zero-wait memory).
- ISSUE: imem_req=0, instr_valid=1. instr and instr_pc are held stable while instr_ready=0.
- On instr_ready=1 in ISSUE, evaluate in this priority order:
  1. halt_req -> HALTED; pc unchanged.
  2. redirect_valid with redirect_target[1:0]!=0 -> FAULT; pc unchanged.
  3. redirect_valid, aligned target -> pc<=redirect_target, then FETCH.
  4. Otherwise -> pc<=pc+4, then FETCH.
- instr_valid drops in the cycle after acceptance.
- redirect_valid and halt_req are sampled only on the accept cycle and ignored in all other states/cycles.
- HALTED: halted=1, imem_req=0. start -> pc<=pc+4, halted<=0, then FETCH.
- FAULT: fault=1, imem_req=0, instr_valid=0. Exit only via rst; start is ignored.
- imem_ack outside FETCH is ignored, including a late ack after rst.
- start outside IDLE/HALTED is ignored.
- PC arithmetic is modulo 2^32: 0xFFFFFFFC+4 = 0x00000000, no flag raised.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE with ready=1).
- Latency: start at cycle 0 -> imem_req=1 with addr 0 at cycle 1 -> instr_valid at cycle 2 if acked at cycle 1.
- rst during FETCH or ISSUE discards the in-flight instruction. No output glitch beyond the asynchronous clear.

Decomposition:
- Shared package holds:
  - state enum: IDLE=0, FETCH=1, ISSUE=2, HALTED=3, FAULT=4, 3-bit encoding;
  - PC_INC=32'd4;
  - default RESET_PC constant;
  - alignment mask 2'b00.
- One natural sub-module: pc_next_mux, combinational. It selects pc+4, redirect_target or hold, and flags misalignment. The FSM, PC register and timeout counter stay in the top module.

Test Plan:
- Reset, then start at cycle 0; memory acks same cycle -> imem_addr=0x0 at cycle 1, instr_valid at cycle 2; with ready=1, addresses 0x0, 0x4, 0x8 every 2 cycles.
- Hold instr_ready=0 for 5 cycles in ISSUE with instr=0xDEADBEEF -> instr/instr_pc stable, imem_req=0, pc unchanged; release -> next fetch at pc+4.
- Accept with redirect_valid=1, target=0x100 -> next imem_addr=0x100; target=0x102 -> fault=1, imem_req=0 permanently until rst.
- Accept with halt_req=1 and redirect_valid=1 -> halted=1, pc unchanged; start -> fetch at pc+4, halted=0.
- No ack for TIMEOUT=16 cycles in FETCH -> fault=1 at the 16th cycle; ack arriving afterwards is ignored.
- Assert rst mid-FETCH with ack pending -> outputs immediately at reset values (pc=0xFFFFFFFC); late ack ignored; start -> fetch at 0x0.
